// File: rtl/line_fill_engine.sv
// rtl/line_fill_engine.sv - cache-line read-fill / write-back engine toward word-wide main memory
module line_fill_engine #(
    parameter int WORD_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int WORDS_PER_LINE = 4,
    localparam int LW            = $clog2(WORDS_PER_LINE),
    localparam int LINE_WIDTH    = WORD_WIDTH * WORDS_PER_LINE,
    localparam int LA            = ADDR_WIDTH - 2 - LW
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [LA-1:0]           req_line_addr,
    input  logic [LINE_WIDTH-1:0]   req_wdata,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic                    resp_write,
    output logic [LINE_WIDTH-1:0]   resp_rdata,
    output logic [WORD_WIDTH-1:0]   mem_write_data,
    output logic [ADDR_WIDTH-3:0]   mem_write_addr,
    output logic                    mem_write_en,
    output logic [ADDR_WIDTH-3:0]   mem_read_addr,
    output logic                    mem_read_addr_valid,
    input  logic                    mem_read_ready,
    input  logic [WORD_WIDTH-1:0]   mem_read_data,
    input  logic                    mem_read_valid
);

    typedef enum logic [2:0] {IDLE, WR, RD_REQ, RD_WAIT, RESP} state_t;

    localparam logic [LW-1:0] LAST_IDX = LW'(WORDS_PER_LINE - 1);

    state_t                  state;
    logic [LW-1:0]           word_idx;
    logic [LA-1:0]           line_addr;
    logic [LINE_WIDTH-1:0]   wbuf;
    logic [LINE_WIDTH-1:0]   rbuf;
    logic [LINE_WIDTH-1:0]   filled;
    logic [LW-1:0]           next_idx;

    // Line buffer with the word arriving this cycle merged in at word_idx.
    always_comb begin
        filled = rbuf;
        filled[word_idx*WORD_WIDTH +: WORD_WIDTH] = mem_read_data;
        next_idx = word_idx + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state               <= IDLE;
            word_idx            <= '0;
            line_addr           <= '0;
            wbuf                <= '0;
            rbuf                <= '0;
            req_ready           <= 1'b1;
            resp_valid          <= 1'b0;
            resp_write          <= 1'b0;
            resp_rdata          <= '0;
            mem_write_data      <= '0;
            mem_write_addr      <= '0;
            mem_write_en        <= 1'b0;
            mem_read_addr       <= '0;
            mem_read_addr_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        line_addr <= req_line_addr;
                        word_idx  <= '0;
                        req_ready <= 1'b0;
                        if (req_write) begin
                            state          <= WR;
                            mem_write_en   <= 1'b1;
                            mem_write_addr <= {req_line_addr, {LW{1'b0}}};
                            mem_write_data <= req_wdata[WORD_WIDTH-1:0];
                            wbuf           <= req_wdata >> WORD_WIDTH;
                        end else begin
                            state               <= RD_REQ;
                            rbuf                <= '0;
                            mem_read_addr_valid <= 1'b1;
                            mem_read_addr       <= {req_line_addr, {LW{1'b0}}};
                        end
                    end
                end
                WR: begin
                    // wbuf is pre-shifted so its low word is always the next word to write.
                    if (word_idx == LAST_IDX) begin
                        state        <= RESP;
                        mem_write_en <= 1'b0;
                        resp_valid   <= 1'b1;
                        resp_write   <= 1'b1;
                        resp_rdata   <= '0;
                    end else begin
                        word_idx       <= next_idx;
                        mem_write_addr <= {line_addr, next_idx};
                        mem_write_data <= wbuf[WORD_WIDTH-1:0];
                        wbuf           <= wbuf >> WORD_WIDTH;
                    end
                end
                RD_REQ: begin
                    if (mem_read_addr_valid && mem_read_ready) begin
                        state               <= RD_WAIT;
                        mem_read_addr_valid <= 1'b0;
                    end
                end
                RD_WAIT: begin
                    if (mem_read_valid) begin
                        rbuf <= filled;
                        if (word_idx == LAST_IDX) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_write <= 1'b0;
                            resp_rdata <= filled;
                        end else begin
                            word_idx            <= next_idx;
                            state               <= RD_REQ;
                            mem_read_addr_valid <= 1'b1;
                            mem_read_addr       <= {line_addr, next_idx};
                        end
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state      <= IDLE;
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_line_fill_engine.sv
// tb/tb_line_fill_engine.sv - directed self-checking bench for line_fill_engine
module tb_line_fill_engine;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid;
    logic         req_ready;
    logic         req_write;
    logic [27:0]  req_line_addr;
    logic [127:0] req_wdata;
    logic         resp_valid;
    logic         resp_ready;
    logic         resp_write;
    logic [127:0] resp_rdata;
    logic [31:0]  mem_write_data;
    logic [29:0]  mem_write_addr;
    logic         mem_write_en;
    logic [29:0]  mem_read_addr;
    logic         mem_read_addr_valid;
    logic         mem_read_ready;
    logic [31:0]  mem_read_data;
    logic         mem_read_valid;

    line_fill_engine dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_line_addr(req_line_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_write(resp_write),
        .resp_rdata(resp_rdata),
        .mem_write_data(mem_write_data), .mem_write_addr(mem_write_addr),
        .mem_write_en(mem_write_en), .mem_read_addr(mem_read_addr),
        .mem_read_addr_valid(mem_read_addr_valid), .mem_read_ready(mem_read_ready),
        .mem_read_data(mem_read_data), .mem_read_valid(mem_read_valid)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;
    int edge_cnt = 0;
    int accept_edge = 0;
    int stall_cnt = 0;
    logic [29:0] stall_addr = '0;
    logic [31:0] mem [0:255];
    logic [29:0] wr_addr [$];
    logic [31:0] wr_data [$];
    int          wr_edge [$];
    logic [29:0] hs_log  [$];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock edge plus the memory model: writes land, a read handshake
    // returns data the next cycle and drops ready for that cycle.
    task automatic step();
        logic        hs, we;
        logic [29:0] ra, wa;
        logic [31:0] wd;
        hs = mem_read_addr_valid && mem_read_ready;
        ra = mem_read_addr;
        we = mem_write_en;
        wa = mem_write_addr;
        wd = mem_write_data;
        @(posedge clk);
        #1;
        edge_cnt++;
        if (we) begin
            mem[wa[7:0]] = wd;
            wr_addr.push_back(wa);
            wr_data.push_back(wd);
            wr_edge.push_back(edge_cnt);
        end
        mem_read_valid = 1'b0;
        mem_read_ready = 1'b1;
        if (hs) begin
            mem_read_valid = 1'b1;
            mem_read_data  = mem[ra[7:0]];
            mem_read_ready = 1'b0;
            hs_log.push_back(ra);
        end else if (stall_cnt > 0 && mem_read_addr_valid && mem_read_addr == stall_addr) begin
            mem_read_ready = 1'b0;
            stall_cnt--;
        end
    endtask

    task automatic send_req(input logic w, input logic [27:0] line, input logic [127:0] wd);
        req_valid = 1'b1;
        req_write = w;
        req_line_addr = line;
        req_wdata = wd;
        check("req_ready_idle", req_ready, 1'b1);
        step();
        accept_edge = edge_cnt;
        req_valid = 1'b0;
    endtask

    // Edge number (accept edge = 1) after which resp_valid was first seen.
    task automatic wait_resp(output int edge_no);
        int n = 0;
        while (!resp_valid && n < 300) begin
            step();
            n++;
        end
        check("resp_timeout", resp_valid, 1'b1);
        edge_no = edge_cnt - accept_edge + 1;
    endtask

    task automatic finish_resp();
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
    endtask

    task automatic clear_logs();
        wr_addr.delete();
        wr_data.delete();
        wr_edge.delete();
        hs_log.delete();
    endtask

    task automatic preload();
        mem[8'h40] = 32'h11; mem[8'h41] = 32'h22; mem[8'h42] = 32'h33; mem[8'h43] = 32'h44;
        mem[8'h44] = 32'h55; mem[8'h45] = 32'h66; mem[8'h46] = 32'h77; mem[8'h47] = 32'h88;
    endtask

    initial begin
        int lat;
        int n;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        rst = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_line_addr = '0; req_wdata = '0;
        resp_ready = 1'b0;
        mem_read_ready = 1'b1; mem_read_valid = 1'b0; mem_read_data = '0;
        step();
        step();
        rst = 1'b0;

        check("rst_req_ready", req_ready, 1'b1);
        check("rst_resp_valid", resp_valid, 1'b0);
        check("rst_resp_write", resp_write, 1'b0);
        check("rst_resp_rdata", resp_rdata, 128'h0);
        check("rst_write_en", mem_write_en, 1'b0);
        check("rst_read_addr_valid", mem_read_addr_valid, 1'b0);
        check("rst_addrs_data", {mem_write_addr, mem_read_addr, mem_write_data}, 92'h0);

        // 1: write-back of line 0x10
        clear_logs();
        send_req(1'b1, 28'h10, {32'hD, 32'hC, 32'hB, 32'hA});
        check("wr_no_read_valid", mem_read_addr_valid, 1'b0);
        wait_resp(lat);
        check("wr_latency", lat, 5);
        check("wr_resp_write", resp_write, 1'b1);
        check("wr_resp_rdata", resp_rdata, 128'h0);
        check("wr_count", wr_addr.size(), 4);
        for (int i = 0; i < 4 && i < wr_addr.size(); i++) begin
            check("wr_addr", wr_addr[i], 30'h40 + 30'(i));
            check("wr_data", wr_data[i], 32'hA + 32'(i));
        end
        if (wr_edge.size() == 4) check("wr_consecutive", wr_edge[3] - wr_edge[0], 3);
        finish_resp();
        check("wr_back_idle", req_ready, 1'b1);

        // 2: read-fill of line 0x10
        preload();
        clear_logs();
        send_req(1'b0, 28'h10, '0);
        wait_resp(lat);
        check("rd_latency", lat, 9);
        check("rd_resp_write", resp_write, 1'b0);
        check("rd_resp_rdata", resp_rdata, 128'h00000044_00000033_00000022_00000011);
        check("rd_hs_count", hs_log.size(), 4);
        for (int i = 0; i < 4 && i < hs_log.size(); i++) check("rd_hs_addr", hs_log[i], 30'h40 + 30'(i));
        finish_resp();

        // 3: memory stalls the word-2 request for 5 cycles
        clear_logs();
        stall_addr = 30'h42;
        stall_cnt = 5;
        send_req(1'b0, 28'h10, '0);
        n = 0;
        while (!(mem_read_addr_valid && mem_read_addr == 30'h42) && n < 50) begin
            step();
            n++;
        end
        check("stall_reach_word2", mem_read_addr_valid, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step();
            check("stall_valid_stable", mem_read_addr_valid, 1'b1);
            check("stall_addr_stable", mem_read_addr, 30'h42);
        end
        wait_resp(lat);
        check("stall_latency", lat, 14);
        check("stall_rdata", resp_rdata, 128'h00000044_00000033_00000022_00000011);
        finish_resp();

        // 4: response back-pressure with a new request already waiting
        send_req(1'b0, 28'h10, '0);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_line_addr = 28'h13;
        req_wdata = {32'h4, 32'h3, 32'h2, 32'h1};
        wait_resp(lat);
        for (int i = 0; i < 3; i++) begin
            step();
            check("bp_resp_valid", resp_valid, 1'b1);
            check("bp_req_ready", req_ready, 1'b0);
            check("bp_resp_write", resp_write, 1'b0);
            check("bp_resp_rdata", resp_rdata, 128'h00000044_00000033_00000022_00000011);
            check("bp_no_write", mem_write_en, 1'b0);
        end
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        check("bp_after_hs_ready", req_ready, 1'b1);
        check("bp_after_hs_resp", resp_valid, 1'b0);
        check("bp_after_hs_no_write", mem_write_en, 1'b0);
        clear_logs();
        step();
        accept_edge = edge_cnt;
        req_valid = 1'b0;
        check("bp_accept_write_en", mem_write_en, 1'b1);
        check("bp_accept_addr", mem_write_addr, 30'h4C);
        wait_resp(lat);
        check("bp_wr_latency", lat, 5);
        finish_resp();

        // 5: reset during RD_WAIT of word 1, then a stale read_valid while idle
        preload();
        clear_logs();
        send_req(1'b0, 28'h10, '0);
        n = 0;
        while (!(hs_log.size() == 2) && n < 50) begin
            step();
            n++;
        end
        check("rst5_in_rd_wait", mem_read_valid, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst5_req_ready", req_ready, 1'b1);
        check("rst5_resp_valid", resp_valid, 1'b0);
        check("rst5_read_addr_valid", mem_read_addr_valid, 1'b0);
        mem_read_valid = 1'b1;
        mem_read_data = 32'hDEAD_BEEF;
        step();
        check("stale_req_ready", req_ready, 1'b1);
        check("stale_resp_valid", resp_valid, 1'b0);
        check("stale_read_addr_valid", mem_read_addr_valid, 1'b0);
        send_req(1'b0, 28'h11, '0);
        wait_resp(lat);
        check("rst5_latency", lat, 9);
        check("rst5_rdata", resp_rdata, 128'h00000088_00000077_00000066_00000055);
        finish_resp();

        // 6: spurious read_valid in IDLE and in WR
        mem_read_valid = 1'b1;
        mem_read_data = 32'hBAD0_0001;
        step();
        check("spur_idle_ready", req_ready, 1'b1);
        check("spur_idle_outputs", {resp_valid, mem_write_en, mem_read_addr_valid}, 3'b000);
        clear_logs();
        send_req(1'b1, 28'h12, {32'h8, 32'h7, 32'h6, 32'h5});
        mem_read_valid = 1'b1;
        mem_read_data = 32'hBAD0_0002;
        step();
        check("spur_wr_still_writing", mem_write_en, 1'b1);
        check("spur_wr_addr", mem_write_addr, 30'h49);
        wait_resp(lat);
        check("spur_wr_latency", lat, 5);
        check("spur_wr_rdata", resp_rdata, 128'h0);
        check("spur_wr_count", wr_addr.size(), 4);
        for (int i = 0; i < 4 && i < wr_addr.size(); i++) begin
            check("spur_wr_addr_seq", wr_addr[i], 30'h48 + 30'(i));
            check("spur_wr_data_seq", wr_data[i], 32'h5 + 32'(i));
        end
        finish_resp();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
